// File: rtl/multi_sym_strategy.sv
// multi_sym_strategy: per-symbol threshold strategy with position limits, cooldowns and a valid/ready order slot
module multi_sym_strategy #(
    parameter int PRICE_W     = 32,
    parameter int QTY_W       = 16,
    parameter int NUM_SYM     = 4,
    parameter int SYM_W       = 2,
    parameter int POS_W       = 20,
    parameter int MAX_POS     = 1000,
    parameter int COOLDOWN    = 8,
    parameter int DEF_BUY_TH  = 1000,
    parameter int DEF_SELL_TH = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               data_valid,
    input  logic [SYM_W-1:0]   sym_id,
    input  logic [PRICE_W-1:0] price,
    input  logic [QTY_W-1:0]   qty,
    input  logic               cfg_we,
    input  logic [SYM_W-1:0]   cfg_sym,
    input  logic [PRICE_W-1:0] cfg_buy_th,
    input  logic [PRICE_W-1:0] cfg_sell_th,
    input  logic               cfg_en,
    output logic               ord_valid,
    input  logic               ord_ready,
    output logic               ord_side,
    output logic [SYM_W-1:0]   ord_sym,
    output logic [PRICE_W-1:0] ord_price,
    output logic [QTY_W-1:0]   ord_qty,
    input  logic [SYM_W-1:0]   pos_rd_sym,
    output logic [POS_W-1:0]   pos_rd_data,
    output logic [15:0]        drop_cnt
);
    localparam int CD_W = COOLDOWN > 0 ? $clog2(COOLDOWN + 1) : 1;
    localparam logic signed [POS_W:0] LIM = (POS_W+1)'(MAX_POS);
    logic               s1_valid;
    logic [SYM_W-1:0]   s1_sym;
    logic [PRICE_W-1:0] s1_price;
    logic [QTY_W-1:0]   s1_qty;
    logic [PRICE_W-1:0] buy_th  [NUM_SYM];
    logic [PRICE_W-1:0] sell_th [NUM_SYM];
    logic [NUM_SYM-1:0] en;
    logic [POS_W-1:0]   pos [NUM_SYM];
    logic [CD_W-1:0]    cd  [NUM_SYM];
    logic signed [POS_W:0] p_ext, q_ext, p_buy, p_sell;
    logic buy_c, sell_c, qual, issue;
    assign pos_rd_data = pos[pos_rd_sym];
    // limit check runs one bit wider than the position so it cannot wrap
    always_comb begin
        p_ext  = {pos[s1_sym][POS_W-1], pos[s1_sym]};
        q_ext  = (POS_W+1)'(s1_qty);
        p_buy  = p_ext + q_ext;
        p_sell = p_ext - q_ext;
        buy_c  = s1_price < buy_th[s1_sym];
        sell_c = !buy_c && s1_price > sell_th[s1_sym];
        qual   = s1_valid && en[s1_sym] && cd[s1_sym] == '0 && (buy_c ? p_buy <= LIM : sell_c && p_sell >= -LIM);
        issue  = qual && (!ord_valid || ord_ready);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sym    <= '0;
            s1_price  <= '0;
            s1_qty    <= '0;
            ord_valid <= 1'b0;
            ord_side  <= 1'b0;
            ord_sym   <= '0;
            ord_price <= '0;
            ord_qty   <= '0;
            drop_cnt  <= '0;
            en        <= '1;
            for (int i = 0; i < NUM_SYM; i++) begin
                buy_th[i]  <= PRICE_W'(DEF_BUY_TH);
                sell_th[i] <= PRICE_W'(DEF_SELL_TH);
                pos[i]     <= '0;
                cd[i]      <= '0;
            end
        end else begin
            s1_valid <= data_valid && int'(sym_id) < NUM_SYM && qty != '0;
            s1_sym   <= sym_id;
            s1_price <= price;
            s1_qty   <= qty;
            for (int i = 0; i < NUM_SYM; i++) begin
                cd[i] <= cd[i] != '0 ? cd[i] - CD_W'(1) : cd[i];
                if (cfg_we && int'(cfg_sym) == i) begin
                    buy_th[i]  <= cfg_buy_th;
                    sell_th[i] <= cfg_sell_th;
                    en[i]      <= cfg_en;
                end
            end
            if (issue) begin
                ord_valid   <= 1'b1;
                ord_side    <= !buy_c;
                ord_sym     <= s1_sym;
                ord_price   <= s1_price;
                ord_qty     <= s1_qty;
                pos[s1_sym] <= buy_c ? p_buy[POS_W-1:0] : p_sell[POS_W-1:0];
                cd[s1_sym]  <= CD_W'(COOLDOWN);
            end else if (ord_ready) begin
                ord_valid <= 1'b0;
            end
            if (qual && !issue && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_multi_sym_strategy.sv
// tb_multi_sym_strategy: directed and randomized checks against an integer reference model
module tb_multi_sym_strategy;
    localparam int MAX_POS  = 1000;
    localparam int COOLDOWN = 8;
    logic        clk = 0, rst_n = 0, data_valid = 0, cfg_we = 0, cfg_en = 1, ord_ready = 1;
    logic [1:0]  sym_id = 0, cfg_sym = 0, pos_rd_sym = 0, ord_sym;
    logic [31:0] price = 0, cfg_buy_th = 0, cfg_sell_th = 0, ord_price;
    logic [15:0] qty = 0, ord_qty, drop_cnt;
    logic        ord_valid, ord_side;
    logic [19:0] pos_rd_data;
    int n_cmp = 0, n_err = 0;
    longint m_buy[4], m_sell[4];
    int m_pos[4], m_cd[4], m_drop, msym, mqty, s1s, s1q, cnt2, cnt3;
    bit m_en[4], s1v, mv, mside;
    longint mprice, s1p;

    multi_sym_strategy dut (
        .clk(clk), .rst_n(rst_n), .data_valid(data_valid), .sym_id(sym_id), .price(price), .qty(qty),
        .cfg_we(cfg_we), .cfg_sym(cfg_sym), .cfg_buy_th(cfg_buy_th), .cfg_sell_th(cfg_sell_th), .cfg_en(cfg_en),
        .ord_valid(ord_valid), .ord_ready(ord_ready), .ord_side(ord_side), .ord_sym(ord_sym),
        .ord_price(ord_price), .ord_qty(ord_qty), .pos_rd_sym(pos_rd_sym), .pos_rd_data(pos_rd_data),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_buy[i] = 1000; m_sell[i] = 1000; m_en[i] = 1; m_pos[i] = 0; m_cd[i] = 0;
        end
        s1v = 0; mv = 0; mside = 0; msym = 0; mprice = 0; mqty = 0; m_drop = 0;
    endfunction

    // One clock: the model consumes the same inputs the DUT samples, then outputs are compared
    task automatic tick();
        bit buy, sell, ok;
        pos_rd_sym = 2'($urandom_range(0, 3));
        @(posedge clk);
        if (!rst_n) model_reset();
        else begin
            buy = 0; sell = 0; ok = 0;
            if (s1v) begin
                buy  = s1p < m_buy[s1s];
                sell = !buy && s1p > m_sell[s1s];
                ok   = m_en[s1s] && m_cd[s1s] == 0 &&
                       (buy ? m_pos[s1s] + s1q <= MAX_POS : sell && m_pos[s1s] - s1q >= -MAX_POS);
            end
            for (int i = 0; i < 4; i++) if (m_cd[i] > 0) m_cd[i]--;
            if (ok && (!mv || ord_ready)) begin
                mv = 1; mside = !buy; msym = s1s; mprice = s1p; mqty = s1q;
                m_pos[s1s] += buy ? s1q : -s1q;
                m_cd[s1s] = COOLDOWN;
            end else begin
                if (mv && ord_ready) mv = 0;
                if (ok && m_drop < 65535) m_drop++;
            end
            if (cfg_we) begin
                m_buy[cfg_sym] = cfg_buy_th; m_sell[cfg_sym] = cfg_sell_th; m_en[cfg_sym] = cfg_en;
            end
            s1v = data_valid && qty != 0; s1s = sym_id; s1p = price; s1q = qty;
        end
        #1;
        check("ord_valid", ord_valid, mv);
        if (mv) begin
            check("ord_side", ord_side, mside);
            check("ord_sym", ord_sym, msym);
            check("ord_price", ord_price, mprice);
            check("ord_qty", ord_qty, mqty);
        end
        check("drop_cnt", drop_cnt, m_drop);
        check("pos_rd", $signed(pos_rd_data), m_pos[pos_rd_sym]);
    endtask

    task automatic send(input int s, input longint p, input int q);
        data_valid = 1; sym_id = 2'(s); price = 32'(p); qty = 16'(q);
        tick();
        data_valid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pos_is(input string tag, input int s, input int exp);
        pos_rd_sym = 2'(s);
        #1;
        check(tag, $signed(pos_rd_data), exp);
    endtask

    initial begin
        model_reset();
        rst_n = 0;
        idle(2);
        rst_n = 1;
        check("reset_valid", ord_valid, 0);
        check("reset_drop", drop_cnt, 0);
        // first order: stage register then output register
        ord_ready = 1;
        send(0, 900, 10);
        check("lat_first_edge", ord_valid, 0);
        tick();
        check("lat_second_edge", ord_valid, 1);
        check("first_side", ord_side, 0);
        check("first_price", ord_price, 900);
        check("first_qty", ord_qty, 10);
        pos_is("first_pos", 0, 10);
        idle(2);
        // equal-to-threshold and between-threshold prices do nothing
        cfg_we = 1; cfg_sym = 1; cfg_buy_th = 500; cfg_sell_th = 700; cfg_en = 1;
        tick();
        cfg_we = 0;
        send(1, 500, 7); send(1, 600, 7); send(1, 700, 7);
        idle(2);
        check("no_order_band", ord_valid, 0);
        send(1, 701, 7);
        tick();
        check("sell_side", ord_side, 1);
        pos_is("sell_pos", 1, -7);
        idle(2);
        // busy slot drops the second order
        ord_ready = 0;
        send(0, 900, 5);
        send(3, 900, 6);
        idle(2);
        check("busy_drop", drop_cnt, 1);
        check("busy_hold_sym", ord_sym, 0);
        check("busy_hold_qty", ord_qty, 5);
        pos_is("busy_pos3", 3, 0);
        ord_ready = 1;
        idle(2);
        // cooldown spacing with sym3 interleaved during sym2's cooldown
        cnt2 = 0; cnt3 = 0;
        for (int i = 1; i <= 28; i++) begin
            if (i <= 27) begin
                data_valid = 1; sym_id = (i == 5 || i == 14) ? 2'd3 : 2'd2; price = 900; qty = 1;
            end
            tick();
            data_valid = 0;
            if (ord_valid && ord_sym == 2) cnt2++;
            if (ord_valid && ord_sym == 3) cnt3++;
        end
        check("cooldown_sym2_orders", cnt2, 3);
        check("cooldown_sym3_orders", cnt3, 2);
        // position limit
        rst_n = 0; tick(); rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            send(0, 900, 400);
            idle(COOLDOWN + 1);
        end
        pos_is("limit_blocked", 0, 800);
        send(0, 900, 200);
        idle(2);
        pos_is("limit_exact", 0, 1000);
        idle(COOLDOWN);
        // reset flushes pending order and full stage register
        ord_ready = 0;
        send(1, 400, 3);
        tick();
        data_valid = 1; sym_id = 2; price = 900; qty = 9;
        rst_n = 0;
        tick();
        data_valid = 0;
        rst_n = 1;
        check("flush_valid", ord_valid, 0);
        check("flush_drop", drop_cnt, 0);
        pos_is("flush_pos1", 1, 0);
        idle(3);
        check("flush_no_stale", ord_valid, 0);
        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            rst_n       = $urandom_range(0, 299) != 0;
            data_valid  = $urandom_range(0, 9) < 7;
            sym_id      = 2'($urandom_range(0, 3));
            price       = $urandom_range(850, 1150);
            qty         = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom_range(1, 300));
            ord_ready   = $urandom_range(0, 9) < 6;
            cfg_we      = $urandom_range(0, 19) == 0;
            cfg_sym     = 2'($urandom_range(0, 3));
            cfg_buy_th  = $urandom_range(900, 1100);
            cfg_sell_th = $urandom_range(900, 1100);
            cfg_en      = $urandom_range(0, 4) != 0;
            tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
